buff_sched_ctrl: RTL
====================

Name: buff_sched_ctrl

Overview:
- Sequencer for the buffer-use decoder in the conv datapath.
- Owns the 5-bit step counter `cnt`, 0..25 per tile, and drives it to the decoder.
- Takes the decoder's 4-bit `buff_use` back and gates it into per-buffer write enables, qualified by an input-stream valid/ready handshake.
- Runs a programmable number of tiles, flushes the pipeline, then reports `done`.

Parameters:
- CNT_W, 5, width of the step counter.
- LAST_CNT, 25, final step index of a tile.
- NUM_BUFF, 4, number of buffers (width of `buff_use` / `buff_en`).
- TILE_W, 8, width of the tile count and tile index.
- DRAIN_CYC, 3, pipeline flush cycles after the last step.

Ports:
- clk, input, 1, clock; all logic on the rising edge.
- reset, input, 1, synchronous active-high reset.
- start, input, 1, begin a job; honoured only in IDLE.
- abort, input, 1, synchronous cancel.
- num_tiles, input, TILE_W, tiles per job; latched on an accepted start.
- in_valid, input, 1, an input data word is present.
- in_ready, output, 1, the controller accepts a word this cycle.
- buff_use, input, NUM_BUFF, decoder output for the current `cnt`.
- cnt, output, CNT_W, registered step index driven to the decoder.
- buff_en, output, NUM_BUFF, per-buffer write enables.
- tile_idx, output, TILE_W, index of the current tile.
- tile_last, output, 1, high during the final step of the final tile.
- busy, output, 1, high in RUN and DRAIN.
- done, output, 1, one-cycle completion pulse.

Behaviour:
- Clock and reset:
  - One clock (`clk`).
  - `reset` is synchronous and active-high; it is sampled on the rising edge of `clk`.
  - Reset values: state=IDLE, cnt=0, tile_idx=0, drain counter=0, latched num_tiles=0, busy=0, done=0.
  - Outputs in reset and IDLE: in_ready=0, buff_en=0, tile_last=0.
- States: IDLE, RUN, DRAIN, DONE (2-bit encoding).
- IDLE:
  - On start=1, latch num_tiles.
  - If num_tiles==0, go to DONE. Otherwise go to RUN with cnt=0 and tile_idx=0.
- RUN:
  - in_ready=1.
  - fire = in_valid & in_ready.
  - buff_en = buff_use & {NUM_BUFF{fire}}. This is combinational, zero latency from fire, and depends on the registered `cnt`.
  - On fire with cnt<LAST_CNT: cnt increments by 1.
  - On fire with cnt==LAST_CNT: cnt wraps to 0 and tile_idx increments.
    - If tile_idx==num_tiles-1, go to DRAIN and load the drain counter with DRAIN_CYC-1.
  - No fire: cnt and tile_idx hold and buff_en=0 (stall).
  - tile_last = (cnt==LAST_CNT) & (tile_idx==num_tiles-1).
  - cnt never exceeds LAST_CNT. Values 26..31 are unreachable.
- DRAIN:
  - in_ready=0, buff_en=0.
  - The drain counter decrements each cycle; at 0, go to DONE.
  - DRAIN lasts exactly DRAIN_CYC cycles.
- DONE:
  - done=1 for exactly one cycle, then return to IDLE.
  - cnt and tile_idx return to 0 on leaving DONE.
- busy = RUN | DRAIN.
- Precedence (highest first): reset, then abort, then normal operation.
  - abort in RUN or DRAIN: next cycle is IDLE, counters clear, and no done pulse.
  - abort in IDLE or DONE: no effect beyond that. A DONE-cycle done pulse still completes.
- start while busy or in DONE is ignored.
- start and abort together in IDLE: abort wins and the controller stays in IDLE.
- reset mid-job: return to reset values on the next edge; any in-flight tile is discarded.
- Width rule: tile_idx is compared against num_tiles-1 at TILE_W bits. num_tiles=255 runs 255 tiles.

Decomposition:
- Shared package (buff_ctrl_pkg):
  - state enum localparams ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE;
  - CNT_W, LAST_CNT, NUM_BUFF.
- No sub-module inside buff_sched_ctrl.
- The decoder stays external and combinational between `cnt` and `buff_use`. The integration wrapper ties them together.

Test Plan:
- Reset then idle:
  - Stimulus: reset=1 for 2 cycles, then release with start=0.
  - Required: cnt=0, buff_en=0, busy=0, done=0, in_ready=0, held across 10 cycles.
- Single tile, no stall, bench using the real decoder:
  - Stimulus: num_tiles=1, start, in_valid=1 continuously.
  - Required: buff_en=0000 at cnt 0..4, 1000 at cnt=5, 1100 at 6, 0011 at 16, 1000 at 25.
  - Required: tile_last=1 at cnt=25; DRAIN lasts 3 cycles; done pulses 26+3+1 cycles after entering RUN.
- Stall:
  - Stimulus: in_valid deasserted for 4 cycles at cnt=9.
  - Required: cnt holds at 9 and buff_en=0000 during the stall. On resume, buff_en=1001 at cnt=9, then cnt advances to 10.
- Multi-tile wrap:
  - Stimulus: num_tiles=3.
  - Required: cnt wraps 25→0 twice, tile_idx goes 0→1→2, 78 fires total, exactly one done pulse.
- Zero tiles and ignored start:
  - Stimulus: num_tiles=0 with start.
  - Required: the DONE pulse is the next cycle, with no RUN and in_ready never 1.
  - Stimulus: start pulsed while busy.
  - Required: tile_idx and the latched num_tiles are unchanged.
- Abort and reset mid-job:
  - Stimulus: abort at cnt=12, tile 1, num_tiles=4.
  - Required: IDLE next cycle, cnt=0, no done pulse.
  - Stimulus: reset asserted during DRAIN.
  - Required: reset values next edge and no done pulse.

Source files
------------

// File: rtl/buff_ctrl_pkg.sv
// Shared constants and state encoding for the buffer-use sequencer.
package buff_ctrl_pkg;

  localparam int unsigned CNT_W     = 5;
  localparam int unsigned LAST_CNT  = 25;
  localparam int unsigned NUM_BUFF  = 4;
  localparam int unsigned TILE_W    = 8;
  localparam int unsigned DRAIN_CYC = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/buff_sched_ctrl.sv
// Step/tile sequencer driving the external buffer-use decoder and gating its
// output into per-buffer write enables under an input valid/ready handshake.
module buff_sched_ctrl
  import buff_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W     = buff_ctrl_pkg::CNT_W,
  parameter int unsigned LAST_CNT  = buff_ctrl_pkg::LAST_CNT,
  parameter int unsigned NUM_BUFF  = buff_ctrl_pkg::NUM_BUFF,
  parameter int unsigned TILE_W    = buff_ctrl_pkg::TILE_W,
  parameter int unsigned DRAIN_CYC = buff_ctrl_pkg::DRAIN_CYC
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [TILE_W-1:0]   num_tiles,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NUM_BUFF-1:0] buff_use,
  output logic [CNT_W-1:0]    cnt,
  output logic [NUM_BUFF-1:0] buff_en,
  output logic [TILE_W-1:0]   tile_idx,
  output logic                tile_last,
  output logic                busy,
  output logic                done
);

  localparam int unsigned DRN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  state_t              state_q,  state_d;
  logic [CNT_W-1:0]    cnt_q,    cnt_d;
  logic [TILE_W-1:0]   tile_q,   tile_d;
  logic [DRN_W-1:0]    drain_q,  drain_d;
  logic [TILE_W-1:0]   ntiles_q, ntiles_d;

  logic fire;
  logic at_last_step;
  logic at_last_tile;

  // Compare at TILE_W bits so num_tiles=255 still yields a last index of 254.
  assign at_last_step = (cnt_q == CNT_W'(LAST_CNT));
  assign at_last_tile = (tile_q == TILE_W'(ntiles_q - 1'b1));

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      tile_q   <= '0;
      drain_q  <= '0;
      ntiles_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tile_q   <= tile_d;
      drain_q  <= drain_d;
      ntiles_q <= ntiles_d;
    end
  end

  // Next-state and counter update; abort outranks normal sequencing.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tile_d   = tile_q;
    drain_d  = drain_q;
    ntiles_d = ntiles_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          ntiles_d = num_tiles;
          cnt_d    = '0;
          tile_d   = '0;
          state_d  = (num_tiles == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          tile_d  = '0;
          drain_d = '0;
        end else if (fire) begin
          if (at_last_step) begin
            cnt_d  = '0;
            tile_d = tile_q + 1'b1;
            if (at_last_tile) begin
              state_d = ST_DRAIN;
              drain_d = DRN_W'(DRAIN_CYC - 1);
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          tile_d  = '0;
          drain_d = '0;
        end else if (drain_q == '0) begin
          state_d = ST_DONE;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        tile_d  = '0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Handshake, enable gating and status outputs.
  always_comb begin
    in_ready  = (state_q == ST_RUN);
    fire      = in_valid & in_ready;
    buff_en   = fire ? buff_use : '0;
    tile_last = in_ready & at_last_step & at_last_tile;
    busy      = (state_q == ST_RUN) | (state_q == ST_DRAIN);
    done      = (state_q == ST_DONE);
  end

  assign cnt      = cnt_q;
  assign tile_idx = tile_q;

endmodule
